reg_file_sb: RTL and testbench

Parametrised multi-register file with a write-pending scoreboard, the next generation of the CPU's 16x16 register storage. Provides one write port, two registered read ports with optional write-to-read bypass, and an optional hardwired zero register. Holds one busy bit per register. The issue stage sets a register's busy bit when it reserves that register as a destination, and the writeback clears it. Read ports report busy so the decode/issue logic can stall on hazards.

---
 rtl/reg_file_sb.sv | 110 +++++++++++
 tb/tb_reg_file_sb.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// Parametrised register file with two registered read ports and a per-register
// busy scoreboard. The issue stage reserves registers and writeback clears them.
module reg_file_sb #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 4,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr_write,
   input  logic [DATA_W-1:0] data_in,
   input  logic              rsv_en,
   input  logic [ADDR_W-1:0] rsv_addr,
   input  logic [ADDR_W-1:0] addr_read1,
   input  logic [ADDR_W-1:0] addr_read2,
   output logic [DATA_W-1:0] data_out1,
   output logic [DATA_W-1:0] data_out2,
   output logic              busy1,
   output logic              busy2,
   output logic [ADDR_W:0]   busy_count,
   output logic              all_idle
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic [DEPTH-1:0]  busy_q, busy_d;
   logic [ADDR_W:0]   busy_count_q, busy_count_d;
   logic [DATA_W-1:0] data_out1_q, data_out1_d;
   logic [DATA_W-1:0] data_out2_q, data_out2_d;
   logic              busy1_q, busy1_d;
   logic              busy2_q, busy2_d;

   logic wr_ok, rsv_ok, cnt_inc, cnt_dec;
   logic rd1_zero, rd2_zero;

   always_comb begin
      // Register 0 swallows writes and reservations when it is hardwired to zero.
      wr_ok    = we && !((ZERO_REG != 0) && (addr_write == '0));
      rsv_ok   = rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));
      rd1_zero = (ZERO_REG != 0) && (addr_read1 == '0);
      rd2_zero = (ZERO_REG != 0) && (addr_read2 == '0);

      mem_d  = mem_q;
      busy_d = busy_q;
      if (wr_ok) begin
         mem_d[addr_write]  = data_in;
         busy_d[addr_write] = 1'b0;
      end
      // Reserve is applied after the write-clear so a new reservation wins.
      if (rsv_ok)
         busy_d[rsv_addr] = 1'b1;

      cnt_inc = rsv_ok && !busy_q[rsv_addr];
      cnt_dec = wr_ok && busy_q[addr_write] && !(rsv_ok && (rsv_addr == addr_write));
      busy_count_d = busy_count_q + {{ADDR_W{1'b0}}, cnt_inc} - {{ADDR_W{1'b0}}, cnt_dec};

      data_out1_d = mem_q[addr_read1];
      data_out2_d = mem_q[addr_read2];
      busy1_d     = busy_q[addr_read1];
      busy2_d     = busy_q[addr_read2];
      if (BYPASS != 0) begin
         if (wr_ok && (addr_write == addr_read1)) data_out1_d = data_in;
         if (wr_ok && (addr_write == addr_read2)) data_out2_d = data_in;
         busy1_d = busy_d[addr_read1];
         busy2_d = busy_d[addr_read2];
      end
      if (rd1_zero) begin
         data_out1_d = '0;
         busy1_d     = 1'b0;
      end
      if (rd2_zero) begin
         data_out2_d = '0;
         busy2_d     = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++)
            mem_q[i] <= '0;
         busy_q       <= '0;
         busy_count_q <= '0;
         data_out1_q  <= '0;
         data_out2_q  <= '0;
         busy1_q      <= 1'b0;
         busy2_q      <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++)
            mem_q[i] <= mem_d[i];
         busy_q       <= busy_d;
         busy_count_q <= busy_count_d;
         data_out1_q  <= data_out1_d;
         data_out2_q  <= data_out2_d;
         busy1_q      <= busy1_d;
         busy2_q      <= busy2_d;
      end
   end

   assign data_out1  = data_out1_q;
   assign data_out2  = data_out2_q;
   assign busy1      = busy1_q;
   assign busy2      = busy2_q;
   assign busy_count = busy_count_q;
   assign all_idle   = (busy_count_q == '0);

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench driving three configurations (bypass, no bypass, zero register)
// from one shared stimulus stream with hand-computed expectations.
module tb_reg_file_sb;

   logic        clk;
   logic        reset_n;
   logic        we;
   logic [3:0]  addr_write;
   logic [15:0] data_in;
   logic        rsv_en;
   logic [3:0]  rsv_addr;
   logic [3:0]  addr_read1;
   logic [3:0]  addr_read2;

   logic [15:0] b_d1, b_d2, n_d1, n_d2, z_d1, z_d2;
   logic        b_b1, b_b2, n_b1, n_b2, z_b1, z_b2;
   logic [4:0]  b_cnt, n_cnt, z_cnt;
   logic        b_idle, n_idle, z_idle;

   int checks   = 0;
   int failures = 0;

   reg_file_sb #(.DATA_W(16), .ADDR_W(4), .BYPASS(1), .ZERO_REG(0)) u_byp (
      .clk(clk), .reset_n(reset_n), .we(we), .addr_write(addr_write), .data_in(data_in),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr), .addr_read1(addr_read1), .addr_read2(addr_read2),
      .data_out1(b_d1), .data_out2(b_d2), .busy1(b_b1), .busy2(b_b2),
      .busy_count(b_cnt), .all_idle(b_idle));

   reg_file_sb #(.DATA_W(16), .ADDR_W(4), .BYPASS(0), .ZERO_REG(0)) u_nobyp (
      .clk(clk), .reset_n(reset_n), .we(we), .addr_write(addr_write), .data_in(data_in),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr), .addr_read1(addr_read1), .addr_read2(addr_read2),
      .data_out1(n_d1), .data_out2(n_d2), .busy1(n_b1), .busy2(n_b2),
      .busy_count(n_cnt), .all_idle(n_idle));

   reg_file_sb #(.DATA_W(16), .ADDR_W(4), .BYPASS(1), .ZERO_REG(1)) u_zero (
      .clk(clk), .reset_n(reset_n), .we(we), .addr_write(addr_write), .data_in(data_in),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr), .addr_read1(addr_read1), .addr_read2(addr_read2),
      .data_out1(z_d1), .data_out2(z_d2), .busy1(z_b1), .busy2(z_b2),
      .busy_count(z_cnt), .all_idle(z_idle));

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      we     = 1'b0;
      rsv_en = 1'b0;
   endtask

   task automatic do_write(input logic [3:0] a, input logic [15:0] d);
      we         = 1'b1;
      addr_write = a;
      data_in    = d;
   endtask

   task automatic do_reserve(input logic [3:0] a);
      rsv_en   = 1'b1;
      rsv_addr = a;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset_n    = 1'b0;
      we         = 1'b0;
      addr_write = '0;
      data_in    = '0;
      rsv_en     = 1'b0;
      rsv_addr   = '0;
      addr_read1 = 4'd3;
      addr_read2 = 4'd7;

      // reset held for two edges
      tick();
      tick();
      chk("rst_d1", {16'h0, b_d1}, 32'h0);
      chk("rst_cnt", {27'h0, b_cnt}, 32'd0);
      chk("rst_idle", {31'h0, b_idle}, 32'd1);
      reset_n = 1'b1;
      tick();
      chk("rd_after_rst_d1", {16'h0, b_d1}, 32'h0);
      chk("rd_after_rst_d2", {16'h0, n_d2}, 32'h0);
      chk("rd_after_rst_b1", {31'h0, b_b1}, 32'd0);
      chk("rd_after_rst_b2", {31'h0, z_b2}, 32'd0);
      chk("rd_after_rst_idle", {31'h0, n_idle}, 32'd1);

      // write 5 with same-edge read of 5
      do_write(4'd5, 16'hBEEF);
      addr_read1 = 4'd5;
      tick();
      chk("nobyp_same_edge_old", {16'h0, n_d1}, 32'h0);
      chk("byp_same_edge_new", {16'h0, b_d1}, 32'hBEEF);
      idle_inputs();
      tick();
      chk("nobyp_next_read", {16'h0, n_d1}, 32'hBEEF);

      // bypass on both ports to the same register
      do_write(4'd2, 16'h1111);
      tick();
      do_write(4'd2, 16'h2222);
      addr_read1 = 4'd2;
      addr_read2 = 4'd2;
      tick();
      chk("byp_d1_2222", {16'h0, b_d1}, 32'h2222);
      chk("byp_d2_2222", {16'h0, b_d2}, 32'h2222);
      chk("nobyp_d1_1111", {16'h0, n_d1}, 32'h1111);
      chk("nobyp_d2_1111", {16'h0, n_d2}, 32'h1111);
      idle_inputs();

      // scoreboard reserve / writeback
      do_reserve(4'd4);
      addr_read1 = 4'd4;
      tick();
      chk("rsv4_cnt", {27'h0, b_cnt}, 32'd1);
      chk("rsv4_byp_busy1", {31'h0, b_b1}, 32'd1);
      chk("rsv4_nobyp_busy1", {31'h0, n_b1}, 32'd0);
      chk("rsv4_idle", {31'h0, b_idle}, 32'd0);
      do_reserve(4'd9);
      addr_read2 = 4'd9;
      tick();
      chk("rsv9_cnt", {27'h0, n_cnt}, 32'd2);
      chk("rsv9_nobyp_busy1", {31'h0, n_b1}, 32'd1);
      chk("rsv9_byp_busy2", {31'h0, b_b2}, 32'd1);
      idle_inputs();
      do_write(4'd4, 16'h0044);
      tick();
      chk("wr4_cnt", {27'h0, b_cnt}, 32'd1);
      chk("wr4_byp_busy1", {31'h0, b_b1}, 32'd0);
      chk("wr4_byp_d1", {16'h0, b_d1}, 32'h0044);
      chk("wr4_nobyp_busy1", {31'h0, n_b1}, 32'd1);
      do_write(4'd9, 16'h0099);
      tick();
      chk("wr9_cnt", {27'h0, b_cnt}, 32'd0);
      chk("wr9_idle", {31'h0, b_idle}, 32'd1);
      idle_inputs();

      // write + reserve on the same register
      do_reserve(4'd6);
      addr_read1 = 4'd6;
      tick();
      do_write(4'd6, 16'h6666);
      do_reserve(4'd6);
      tick();
      chk("wr_rsv6_cnt", {27'h0, b_cnt}, 32'd1);
      chk("wr_rsv6_byp_busy1", {31'h0, b_b1}, 32'd1);
      chk("wr_rsv6_byp_d1", {16'h0, b_d1}, 32'h6666);
      idle_inputs();
      tick();
      chk("wr_rsv6_nobyp_d1", {16'h0, n_d1}, 32'h6666);
      chk("wr_rsv6_nobyp_busy1", {31'h0, n_b1}, 32'd1);
      do_write(4'd8, 16'h8888);
      do_reserve(4'd8);
      tick();
      chk("wr_rsv8_cnt_inc", {27'h0, b_cnt}, 32'd2);
      idle_inputs();

      // reserve every register, then reserve one more
      for (int i = 0; i < 16; i++) begin
         do_reserve(i[3:0]);
         tick();
      end
      chk("all_rsv_cnt", {27'h0, b_cnt}, 32'd16);
      chk("all_rsv_zero_cnt", {27'h0, z_cnt}, 32'd15);
      do_reserve(4'd3);
      tick();
      chk("all_rsv_again_cnt", {27'h0, b_cnt}, 32'd16);
      idle_inputs();
      for (int i = 0; i < 16; i++) begin
         do_write(i[3:0], 16'h0101 * i[15:0]);
         tick();
      end
      idle_inputs();
      chk("all_clr_cnt", {27'h0, b_cnt}, 32'd0);
      chk("all_clr_zero_idle", {31'h0, z_idle}, 32'd1);

      // hardwired zero register
      do_write(4'd0, 16'hFFFF);
      do_reserve(4'd0);
      addr_read1 = 4'd0;
      addr_read2 = 4'd0;
      tick();
      chk("zero_d1", {16'h0, z_d1}, 32'h0);
      chk("zero_d2", {16'h0, z_d2}, 32'h0);
      chk("zero_busy1", {31'h0, z_b1}, 32'd0);
      chk("zero_cnt", {27'h0, z_cnt}, 32'd0);
      chk("nozero_d1", {16'h0, b_d1}, 32'hFFFF);
      chk("nozero_cnt", {27'h0, b_cnt}, 32'd1);
      idle_inputs();
      tick();
      chk("zero_d1_hold", {16'h0, z_d1}, 32'h0);

      // asynchronous reset with reservations pending and a write in flight
      addr_read1 = 4'd1;
      for (int i = 1; i < 4; i++) begin
         do_reserve(i[3:0]);
         tick();
      end
      idle_inputs();
      chk("pre_rst_zero_cnt", {27'h0, z_cnt}, 32'd3);
      chk("pre_rst_byp_cnt", {27'h0, b_cnt}, 32'd4);
      chk("pre_rst_busy1", {31'h0, z_b1}, 32'd1);
      do_write(4'd5, 16'h5A5A);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_rst_zero_cnt", {27'h0, z_cnt}, 32'd0);
      chk("async_rst_byp_cnt", {27'h0, b_cnt}, 32'd0);
      chk("async_rst_busy1", {31'h0, z_b1}, 32'd0);
      chk("async_rst_idle", {31'h0, b_idle}, 32'd1);
      tick();
      idle_inputs();
      reset_n    = 1'b1;
      addr_read1 = 4'd5;
      addr_read2 = 4'd2;
      tick();
      chk("post_rst_d1", {16'h0, n_d1}, 32'h0);
      chk("post_rst_busy2", {31'h0, n_b2}, 32'd0);

      // final report
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
